// File: rtl/param_lfsr.sv
// Parameterised Fibonacci-style LFSR random source.
// Each request advances the register STEPS times, then presents the low OUT_W bits.
module param_lfsr #(
    parameter int                WIDTH = 8,
    parameter logic [WIDTH-1:0]  TAPS  = 8'hB8,
    parameter logic [WIDTH-1:0]  SEED  = 8'h01,
    parameter int                OUT_W = 3,
    parameter int                STEPS = 4
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             req,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    output logic             rnd_valid,
    output logic [OUT_W-1:0] rnd_out,
    output logic             busy,
    output logic [WIDTH-1:0] lfsr_state
);

    // state  | meaning
    // IDLE   | register holds; accepts req or seed_load
    // RUN    | one shift per cycle while the step counter runs down
    // DONE   | rnd_out freshly updated, rnd_valid pulses
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [7:0] STEP_CNT = 8'(STEPS);

    logic [1:0]       fsm_q;
    logic [7:0]       cnt_q;
    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] shift_nxt;
    logic             fb;

    // An all-zero register would never leave zero, so recover to SEED.
    always_comb begin
        fb        = ^(state_q & TAPS);
        shift_nxt = (state_q == '0) ? SEED : {state_q[WIDTH-2:0], fb};
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            fsm_q     <= S_IDLE;
            cnt_q     <= 8'd0;
            state_q   <= SEED;
            rnd_valid <= 1'b0;
            rnd_out   <= '0;
        end else begin
            rnd_valid <= 1'b0;
            case (fsm_q)
                S_IDLE: begin
                    if (seed_load) begin
                        state_q <= (seed_in == '0) ? SEED : seed_in;
                    end else if (req) begin
                        fsm_q <= S_RUN;
                        cnt_q <= STEP_CNT;
                    end
                end
                S_RUN: begin
                    state_q <= shift_nxt;
                    if (cnt_q == 8'd1) begin
                        fsm_q     <= S_DONE;
                        cnt_q     <= 8'd0;
                        rnd_valid <= 1'b1;
                        rnd_out   <= shift_nxt[OUT_W-1:0];
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                S_DONE: begin
                    fsm_q <= S_IDLE;
                end
                default: begin
                    fsm_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy       = (fsm_q == S_RUN) || (fsm_q == S_DONE);
    assign lfsr_state = state_q;

endmodule

// File: tb/tb_param_lfsr.sv
// Directed bench for param_lfsr: default instance plus a STEPS=1 instance for the full period walk.
module tb_param_lfsr;

    logic       clock;
    logic       resetn;
    logic       req;
    logic       seed_load;
    logic [7:0] seed_in;
    logic       rnd_valid;
    logic [2:0] rnd_out;
    logic       busy;
    logic [7:0] lfsr_state;

    logic       req2;
    logic       rnd_valid2;
    logic [2:0] rnd_out2;
    logic       busy2;
    logic [7:0] lfsr_state2;

    int checks = 0;
    int errors = 0;

    param_lfsr dut (
        .clock      (clock),
        .resetn     (resetn),
        .req        (req),
        .seed_load  (seed_load),
        .seed_in    (seed_in),
        .rnd_valid  (rnd_valid),
        .rnd_out    (rnd_out),
        .busy       (busy),
        .lfsr_state (lfsr_state)
    );

    param_lfsr #(.STEPS(1)) dut1 (
        .clock      (clock),
        .resetn     (resetn),
        .req        (req2),
        .seed_load  (1'b0),
        .seed_in    (8'h00),
        .rnd_valid  (rnd_valid2),
        .rnd_out    (rnd_out2),
        .busy       (busy2),
        .lfsr_state (lfsr_state2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; req = 1'b0; req2 = 1'b0; seed_load = 1'b0; seed_in = 8'h00;
        tick(); tick();
        resetn = 1'b1;
        checks++;
        if (lfsr_state !== 8'h01 || busy !== 1'b0 || rnd_valid !== 1'b0 || rnd_out !== 3'b000) begin
            errors++;
            $display("FAIL reset: state=%h busy=%b valid=%b out=%b, want 01 0 0 000",
                     lfsr_state, busy, rnd_valid, rnd_out);
        end
        tick();
        checks++;
        if (lfsr_state !== 8'h01 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold_after_reset: state=%h busy=%b, want 01 0", lfsr_state, busy);
        end
    endtask

    task automatic test_single();
        logic [7:0] exp_st [4] = '{8'h02, 8'h04, 8'h08, 8'h11};
        req = 1'b1;
        tick();
        req = 1'b0;
        checks++;
        if (busy !== 1'b1 || lfsr_state !== 8'h01 || rnd_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_accept: busy=%b state=%h valid=%b, want 1 01 0", busy, lfsr_state, rnd_valid);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (lfsr_state !== exp_st[k] || busy !== 1'b1 || rnd_valid !== (k == 3)) begin
                errors++;
                $display("FAIL single_step%0d: state=%h busy=%b valid=%b, want %h 1 %b",
                         k, lfsr_state, busy, rnd_valid, exp_st[k], (k == 3));
            end
        end
        checks++;
        if (rnd_out !== 3'b001) begin
            errors++;
            $display("FAIL single_out: rnd_out=%b, want 001", rnd_out);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || rnd_valid !== 1'b0 || lfsr_state !== 8'h11 || rnd_out !== 3'b001) begin
            errors++;
            $display("FAIL single_end: busy=%b valid=%b state=%h out=%b, want 0 0 11 001",
                     busy, rnd_valid, lfsr_state, rnd_out);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_st [4] = '{8'h23, 8'h47, 8'h8E, 8'h1C};
        req = 1'b1;
        tick();
        req = 1'b0;
        // seed_load arriving mid-sequence must be ignored
        seed_load = 1'b1; seed_in = 8'h5A;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (lfsr_state !== exp_st[k]) begin
                errors++;
                $display("FAIL b2b_step%0d: state=%h, want %h", k, lfsr_state, exp_st[k]);
            end
        end
        seed_load = 1'b0; seed_in = 8'h00;
        checks++;
        if (rnd_valid !== 1'b1 || rnd_out !== 3'b100) begin
            errors++;
            $display("FAIL b2b_out: valid=%b out=%b, want 1 100", rnd_valid, rnd_out);
        end
        tick();
    endtask

    task automatic test_hold();
        for (int k = 0; k < 5; k++) tick();
        checks++;
        if (lfsr_state !== 8'h1C || rnd_out !== 3'b100 || busy !== 1'b0 || rnd_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold: state=%h out=%b busy=%b valid=%b, want 1C 100 0 0",
                     lfsr_state, rnd_out, busy, rnd_valid);
        end
    endtask

    task automatic test_req_held();
        int         pulses[$];
        logic [2:0] held;
        int         hold_bad = 0;
        int         waited = 0;
        req = 1'b1;
        held = rnd_out;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rnd_valid) begin
                pulses.push_back(i);
                held = rnd_out;
            end else if (rnd_out !== held) begin
                hold_bad++;
            end
        end
        req = 1'b0;
        checks++;
        if (pulses.size() != 3) begin
            errors++;
            $display("FAIL held_pulse_count: got %0d pulses, want 3", pulses.size());
        end else begin
            checks++;
            if (pulses[0] != 4 || pulses[1] != 10 || pulses[2] != 16) begin
                errors++;
                $display("FAIL held_pulse_spacing: cycles %0d,%0d,%0d, want 4,10,16",
                         pulses[0], pulses[1], pulses[2]);
            end
        end
        checks++;
        if (hold_bad != 0) begin
            errors++;
            $display("FAIL held_out_stable: rnd_out changed %0d times outside pulses, want 0", hold_bad);
        end
        while (busy && waited < 12) begin
            tick();
            waited++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL held_drain: busy=%b after %0d cycles, want 0", busy, waited);
        end
    endtask

    task automatic test_seed();
        seed_load = 1'b1; seed_in = 8'h00;
        tick();
        seed_load = 1'b0;
        checks++;
        if (lfsr_state !== 8'h01 || busy !== 1'b0) begin
            errors++;
            $display("FAIL seed_zero: state=%h busy=%b, want 01 0", lfsr_state, busy);
        end
        seed_load = 1'b1; seed_in = 8'h5A; req = 1'b1;
        tick();
        seed_load = 1'b0; seed_in = 8'h00; req = 1'b0;
        checks++;
        if (lfsr_state !== 8'h5A || busy !== 1'b0) begin
            errors++;
            $display("FAIL seed_priority: state=%h busy=%b, want 5A 0", lfsr_state, busy);
        end
        tick(); tick();
        checks++;
        if (lfsr_state !== 8'h5A || busy !== 1'b0 || rnd_valid !== 1'b0) begin
            errors++;
            $display("FAIL seed_no_run: state=%h busy=%b valid=%b, want 5A 0 0", lfsr_state, busy, rnd_valid);
        end
    endtask

    task automatic test_reset_abort();
        int seen_valid = 0;
        req = 1'b1;
        tick();
        req = 1'b0;
        tick();
        resetn = 1'b0;
        tick();
        checks++;
        if (lfsr_state !== 8'h01 || busy !== 1'b0 || rnd_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_reset: state=%h busy=%b valid=%b, want 01 0 0", lfsr_state, busy, rnd_valid);
        end
        resetn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rnd_valid || busy) seen_valid++;
        end
        checks++;
        if (seen_valid != 0 || lfsr_state !== 8'h01) begin
            errors++;
            $display("FAIL abort_no_pulse: active cycles=%0d state=%h, want 0 01", seen_valid, lfsr_state);
        end
    endtask

    task automatic test_period();
        logic       seen [256];
        int         dup = 0;
        int         timeouts = 0;
        int         w;
        logic [7:0] last = 8'h00;
        for (int i = 0; i < 256; i++) seen[i] = 1'b0;
        req2 = 1'b1;
        for (int n = 0; n < 255; n++) begin
            w = 0;
            do begin
                tick();
                w++;
            end while (!rnd_valid2 && w < 6);
            if (!rnd_valid2) begin
                timeouts++;
            end else begin
                if (seen[lfsr_state2] || lfsr_state2 == 8'h00) dup++;
                seen[lfsr_state2] = 1'b1;
                last = lfsr_state2;
            end
        end
        req2 = 1'b0;
        tick(); tick();
        checks++;
        if (timeouts != 0) begin
            errors++;
            $display("FAIL period_timeout: %0d requests without rnd_valid, want 0", timeouts);
        end
        checks++;
        if (dup != 0) begin
            errors++;
            $display("FAIL period_distinct: %0d repeated or zero states, want 0", dup);
        end
        checks++;
        if (last !== 8'h01 || lfsr_state2 !== 8'h01) begin
            errors++;
            $display("FAIL period_wrap: last=%h state=%h, want 01 01", last, lfsr_state2);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_hold();
        test_req_held();
        test_seed();
        test_reset_abort();
        test_period();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
